// File: rtl/dispatcher_mc.sv
// Stream dispatcher: parses a one-beat command header on an AXI4-Stream input
// and steers the following payload beats to one of NUM_CH scan engines.
// Packets with a bad magic value, an out-of-range channel, or no payload are
// discarded and counted in a saturating drop counter.
module dispatcher_mc #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned NUM_CH = 4,
    parameter logic [23:0] MAGIC  = 24'hAECAFE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tstrb,
    input  logic [127:0]          s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [NUM_CH-1:0]     dpt_dvld,
    output logic [NUM_CH-1:0]     dpt_end,
    output logic [7:0]            dpt_cmd,
    output logic [23:0]           dpt_id,
    output logic [31:0]           dpt_poff,
    output logic [DATA_W-1:0]     dpt_data,
    output logic [DATA_W/8-1:0]   dpt_bvld,
    input  logic [NUM_CH-1:0]     scn_rdy,
    output logic [15:0]           drop_cnt
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_PACKET = 2'd1,
        ST_DROP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              tran_end_q, tran_end_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [23:0]       id_q, id_d;
    logic [31:0]       poff_q, poff_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    // Header field decode from the current beat
    logic [23:0]       hdr_magic;
    logic [7:0]        hdr_cmd;
    logic [23:0]       hdr_id;
    logic              hdr_tran_end;
    logic              hdr_poff_vld;
    logic [31:0]       hdr_poff;
    logic [CH_W-1:0]   hdr_ch;
    logic              hdr_magic_ok;
    logic              hdr_ch_ok;
    logic              hdr_good;
    logic              sel_rdy;

    assign hdr_magic    = s_axis_tdata[23:0];
    assign hdr_cmd      = s_axis_tdata[31:24];
    assign hdr_id       = s_axis_tdata[55:32];
    assign hdr_tran_end = s_axis_tdata[56];
    assign hdr_poff_vld = s_axis_tdata[57];
    assign hdr_poff     = s_axis_tdata[95:64];
    assign hdr_ch       = hdr_id[CH_W-1:0];
    assign hdr_magic_ok = (hdr_magic == MAGIC);
    assign hdr_ch_ok    = (32'(hdr_ch) < NUM_CH);
    // A header that is also the last beat carries no payload and is dropped
    assign hdr_good     = hdr_magic_ok & hdr_ch_ok & ~s_axis_tlast;
    assign sel_rdy      = scn_rdy[ch_q];

    // Payload fields pass straight through; the source holds them during stalls
    assign dpt_data = s_axis_tdata;
    assign dpt_bvld = s_axis_tstrb;
    assign dpt_cmd  = cmd_q;
    assign dpt_id   = id_q;
    assign dpt_poff = poff_q;
    assign drop_cnt = drop_cnt_q;

    // Header bits beyond the defined fields and tuser carry nothing for this block
    logic unused_c;
    assign unused_c = ^{s_axis_tuser, s_axis_tdata[63:58], s_axis_tdata[DATA_W-1:96]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in HEADER every valid beat is consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HEADER: begin
                if (s_axis_tvalid) begin
                    if (hdr_good) begin
                        state_d = ST_PACKET;
                    end else if (!s_axis_tlast) begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PACKET: begin
                if (s_axis_tvalid && sel_rdy && s_axis_tlast) begin
                    state_d = ST_HEADER;
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_HEADER;
                end
            end
            default: state_d = ST_HEADER;
        endcase
    end

    // Output decode: zero-cycle passthrough to the selected channel
    always_comb begin
        s_axis_tready = 1'b1;
        dpt_dvld      = '0;
        dpt_end       = '0;
        if (state_q == ST_PACKET) begin
            s_axis_tready  = sel_rdy;
            dpt_dvld[ch_q] = s_axis_tvalid;
            dpt_end[ch_q]  = s_axis_tvalid & s_axis_tlast & tran_end_q;
        end
    end

    // Header latch and saturating drop counter next values
    always_comb begin
        ch_d       = ch_q;
        tran_end_d = tran_end_q;
        cmd_d      = cmd_q;
        id_d       = id_q;
        poff_d     = poff_q;
        drop_cnt_d = drop_cnt_q;
        if (state_q == ST_HEADER && s_axis_tvalid) begin
            if (hdr_good) begin
                ch_d       = hdr_ch;
                tran_end_d = hdr_tran_end;
                cmd_d      = hdr_cmd;
                id_d       = hdr_id;
                if (hdr_poff_vld) begin
                    poff_d = hdr_poff;
                end
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // Header and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q       <= '0;
            tran_end_q <= 1'b0;
            cmd_q      <= '0;
            id_q       <= '0;
            poff_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            ch_q       <= ch_d;
            tran_end_q <= tran_end_d;
            cmd_q      <= cmd_d;
            id_q       <= id_d;
            poff_q     <= poff_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
